fp_redc: RTL
============

# fp_redc

Sequential modular-reduction stage that sits directly downstream of `intmul` in the `fp_mul` datapath. It consumes the 510-bit integer product and returns the 251-bit Montgomery-reduced residue `out = D · 2^-248 mod p`, where `p = 5·2^248 − 1`. The block uses a one-cycle fold that exploits `−p^-1 ≡ 1 (mod 2^248)`, followed by a 13-step shifted compare-subtract loop. A valid/ready handshake is provided on both sides so the `fp_mul` wrapper can stall it.

## Interface
- `IN_W`, 510, width of the product input from `intmul`.
- `R_LOG`, 248, Montgomery exponent; the fold split point.
- `OUT_W`, 251, residue width, equal to the bit length of p.
- `SUB_STEPS`, 13, number of compare-subtract iterations (k = 12 down to 0).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `D` is valid.
- `in_ready`  out  1  block is idle and can accept a product.
- `D`  in  510  product from `intmul`, treated as an unsigned integer.
- `out_valid`  out  1  `out` holds a completed residue.
- `out_ready`  in  1  the consumer takes `out`.
- `out`  out  251  result in the range [0, p).

## Operation
States: IDLE, SUB, DONE.

**IDLE**
- `in_ready`=1.
- On an edge where `in_valid & in_ready` is true:
  - Load `t` (a 263-bit register) with `D[509:248] + 5·D[247:0]`.
  - Set `k` (a 4-bit counter) to 12.
  - Go to SUB.

**SUB**
- Each edge: if `t ≥ (p << k)`, then `t ← t − (p << k)`.
- If `k`=0, go to DONE and load `out ← t[250:0]`; otherwise `k ← k−1`.
- Invariant after step k: `t < p << k`.
  - The loop starts correctly because the fold gives `t < 2^262 + 5·2^248 < p << 13`.
  - After k=0, `t < p` is guaranteed.
- `in_valid` is ignored; `in_ready`=0.

**DONE**
- `out_valid`=1; `out` is held stable.
- On an edge with `out_ready`=1: `out_valid ← 0`, go to IDLE. `out` keeps its last value.

**Arithmetic rules**
- All arithmetic is unsigned.
- The fold sum is computed at 263-bit width with no truncation.
- The compare and the subtract share one 263-bit subtractor; the borrow-out is the "t < p<<k" decision.
- No modular pre-check is performed on `D`: any 510-bit value is legal, including values ≥ p².

**Reset**
- Asynchronous when `rst`=0. An in-flight operation is abandoned with no partial output.
- Reset values: state=IDLE, `in_ready`=0, `out_valid`=0, `out`=0, `t`=0, `k`=0.
- `in_ready` is registered and rises on the first rising edge after `rst` deasserts.

## Timing
- Acceptance edge E0 loads the fold result.
- Edges E1..E13 perform subtraction steps k=12..0.
- `out_valid` is high after E13: latency is 13 cycles from the accepting edge to `out_valid`.
- Throughput: at best one result per 15 cycles (accept, 13 SUB cycles, 1 DONE handshake cycle). `in_ready` returns the cycle after the output handshake.
- Back-pressure: DONE holds indefinitely while `out_ready`=0, and `out` must not change during that time.
- Simultaneous events: a new `in_valid` arriving in DONE or SUB is not accepted. The upstream holds `D` until `in_ready`.
- Critical path: one 263-bit subtract plus a 2:1 mux. The fold adder, `5·x` computed as `(x<<2)+x`, is a single-cycle 263-bit add.

## Test plan
- **Unity factor:** `D`=2^248 → `out`=1 after exactly 13 cycles. Check that `out_valid` rises on the 13th edge after acceptance.
- **Low word only:**
  - `D`=1 → `out`=5 (since 2^-248 ≡ 5 mod p).
  - `D`=2^248−1 → `out`=p−4 = 5·2^248−5. This checks that no over-subtraction occurs.
- **Boundaries:**
  - `D`=0 → 0.
  - `D`=p·2^248 → 0.
  - `D`=(p−1)·2^248 → p−1.
  - `D`=2^510−1 → matches a software model of `D·5^... ≡ D·2^-248 mod p`, with `out` < p.
- **Back-pressure:** hold `out_ready`=0 for 20 cycles after `out_valid`. `out` must stay stable, `in_ready` must stay 0, and a pulsed `in_valid` must be ignored. Then set `out_ready`=1: `out_valid` falls on that edge and `in_ready` rises on the next cycle.
- **Reset mid-operation:** assert `rst`=0 at SUB step k=6. `out_valid`, `in_ready` and `out` go to 0 immediately (asynchronously). After release, `in_ready`=1 one edge later, and a fresh `D`=2^248 yields 1.
- **Chained with `intmul`:** 1000 random 255-bit A and B pairs, with products fed through. Compare `out` against `(A·B·2^-248) mod p` from the reference model, with zero mismatches.

Source files
------------

// File: rtl/fp_redc_if.sv
// Handshake bundle between intmul's product stream and fp_redc's residue stream.
// The slave modport is the reduction block's own view of the bundle.
interface fp_redc_if #(
    parameter int IN_W  = 510,
    parameter int OUT_W = 251
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  D;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;

    modport master (
        output in_valid, D, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, D, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fp_redc.sv
// Montgomery reduction by 2^248 for p = 5*2^248 - 1.
// A one-cycle fold is followed by 13 shifted compare-subtract steps.
module fp_redc #(
    parameter int IN_W      = 510,
    parameter int R_LOG     = 248,
    parameter int OUT_W     = 251,
    parameter int SUB_STEPS = 13
) (
    input  logic      clk,
    input  logic      rst,
    fp_redc_if.slave  bus
);
    localparam int T_W  = OUT_W + SUB_STEPS - 1;
    localparam int HI_W = IN_W - R_LOG;
    localparam int K_W  = $clog2(SUB_STEPS);
    localparam logic [T_W-1:0] P =
        ({{(T_W-3){1'b0}}, 3'd5} << R_LOG) - {{(T_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t         state;
    logic [T_W-1:0] t;
    logic [K_W-1:0] k;

    logic [HI_W-1:0]  hi;
    logic [R_LOG-1:0] lo;
    logic [T_W-1:0]   fold;
    logic [T_W-1:0]   psh;
    logic [T_W:0]     diff;
    logic             borrow;
    logic [T_W-1:0]   t_nxt;

    // D*2^-R == hi + lo*2^-R, and 2^-R == 5 (mod p) since 5*2^R == p+1.
    assign hi     = bus.D[IN_W-1:R_LOG];
    assign lo     = bus.D[R_LOG-1:0];
    assign fold   = T_W'(hi) + (T_W'(lo) << 2) + T_W'(lo);

    // A single subtractor decides and subtracts; its borrow means t < p<<k.
    assign psh    = P << k;
    assign diff   = {1'b0, t} - {1'b0, psh};
    assign borrow = diff[T_W];
    assign t_nxt  = borrow ? t : diff[T_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            t             <= '0;
            k             <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        t            <= fold;
                        k            <= K_W'(SUB_STEPS - 1);
                        bus.in_ready <= 1'b0;
                        state        <= SUB;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                SUB: begin
                    t <= t_nxt;
                    if (k == '0) begin
                        bus.out       <= t_nxt[OUT_W-1:0];
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                DONE: begin
                    // in_ready is raised here so a new product can land one edge later.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
